// File: rtl/nikor_clock_pkg.sv
// Shared constants and the seven-segment decoder for the nikor multi-digit clock.
// Segment bit 0 is 'a' and bit 6 is 'g'.
package nikor_clock_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-BCD codes can never be reached, so they simply show nothing.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/nikor_bcd_digit.sv
// One decade of the BCD counter; carry_out pulses when this digit rolls over
// (9->0 counting up, 0->9 counting down) and becomes the next digit's step.
module nikor_bcd_digit
    import nikor_clock_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             up,
    input  logic             clear,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    assign carry_out = step && !clear &&
                       (up ? (digit == BCD_W'(9)) : (digit == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else if (step) begin
            if (up) digit <= (digit == BCD_W'(9)) ? '0 : digit + 1'b1;
            else    digit <= (digit == '0) ? BCD_W'(9) : digit - 1'b1;
        end
    end

endmodule

// File: rtl/nikor_clock_mux.sv
// Multi-digit BCD clock: prescaled up/down counter plus a time-multiplexed
// seven-segment display with one-hot digit select and optional leading-zero blanking.
module nikor_clock_mux
    import nikor_clock_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 2,
    parameter int LZ_BLANK    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              clear,
    output logic [6:0]        segments,
    output logic [DIGITS-1:0] digit_sel,
    output logic              tick,
    output logic              wrap
);

    localparam int PRE_W = (CLK_DIV > 1)     ? $clog2(CLK_DIV)     : 1;
    localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;

    logic [PRE_W-1:0]        pre;
    logic [RC_W-1:0]         rc;
    logic [IDX_W-1:0]        idx;
    logic                    term;
    logic [DIGITS:0]         carry;
    logic [DIGITS*BCD_W-1:0] digits;
    logic [BCD_W-1:0]        cur_digit;
    logic                    blank;
    logic                    above_zero;
    logic [DIGITS-1:0]       next_sel;

    assign term     = en && (pre == PRE_W'(CLK_DIV - 1));
    assign carry[0] = term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre  <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            tick <= term && !clear;
            wrap <= carry[DIGITS];
            if (clear)     pre <= '0;
            else if (term) pre <= '0;
            else if (en)   pre <= pre + 1'b1;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        nikor_bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .step      (carry[k]),
            .up        (up),
            .clear     (clear),
            .digit     (digits[k*BCD_W +: BCD_W]),
            .carry_out (carry[k+1])
        );
    end

    // Scan runs freely; clear and en deliberately have no effect on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc  <= '0;
            idx <= '0;
        end else if (rc == RC_W'(REFRESH_DIV - 1)) begin
            rc  <= '0;
            idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            rc <= rc + 1'b1;
        end
    end

    // Walk from the top digit down so above_zero tracks "this digit and all above are 0".
    always_comb begin
        cur_digit  = '0;
        blank      = 1'b0;
        above_zero = 1'b1;
        next_sel   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            above_zero = above_zero && (digits[k*BCD_W +: BCD_W] == '0);
            if (idx == IDX_W'(k)) begin
                cur_digit   = digits[k*BCD_W +: BCD_W];
                blank       = (LZ_BLANK != 0) && (k > 0) && above_zero;
                next_sel[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments  <= SEG_0;
            digit_sel <= DIGITS'(1);
        end else begin
            segments  <= blank ? SEG_BLANK : seg7(cur_digit);
            digit_sel <= next_sel;
        end
    end

endmodule

// File: tb/tb_nikor_clock_mux.sv
// Self-checking bench for nikor_clock_mux (3 digits, blanking on): directed
// vectors plus randomized control checked against an integer-level reference model.
module tb_nikor_clock_mux;

    localparam int CD  = 4;
    localparam int DG  = 3;
    localparam int RD  = 3;
    localparam int LZ  = 1;
    localparam int MOD = 1000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       up    = 1'b1;
    logic       clear = 1'b0;
    logic [6:0] segments;
    logic [2:0] digit_sel;
    logic       tick;
    logic       wrap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nikor_clock_mux #(
        .CLK_DIV     (CD),
        .DIGITS      (DG),
        .REFRESH_DIV (RD),
        .LZ_BLANK    (LZ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .clear     (clear),
        .segments  (segments),
        .digit_sel (digit_sel),
        .tick      (tick),
        .wrap      (wrap)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic u, input logic c);
        en    = e;
        up    = u;
        clear = c;
    endtask

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] model_display(input int v, input int k);
        if (LZ != 0 && k > 0 && v < pow10(k)) return 7'h00;
        return exp_seg((v / pow10(k)) % 10);
    endfunction

    // Reference model: counter kept as a plain integer 0..999.
    int         m_pre, m_val, m_rc, m_idx;
    logic       m_tick, m_wrap;
    logic [6:0] m_seg;
    logic [2:0] m_sel;

    always @(posedge clk or negedge rst_n) begin : ref_model
        int nv;
        int np;
        logic nt;
        logic nw;
        if (!rst_n) begin
            m_pre  <= 0;
            m_val  <= 0;
            m_rc   <= 0;
            m_idx  <= 0;
            m_tick <= 1'b0;
            m_wrap <= 1'b0;
            m_seg  <= 7'h3F;
            m_sel  <= 3'b001;
        end else begin
            nv = m_val;
            np = m_pre;
            nt = 1'b0;
            nw = 1'b0;
            if (clear) begin
                nv = 0;
                np = 0;
            end else if (en) begin
                if (m_pre == CD - 1) begin
                    np = 0;
                    nt = 1'b1;
                    if (up) begin
                        nw = (m_val == MOD - 1);
                        nv = (m_val + 1) % MOD;
                    end else begin
                        nw = (m_val == 0);
                        nv = (m_val + MOD - 1) % MOD;
                    end
                end else begin
                    np = m_pre + 1;
                end
            end
            m_seg <= model_display(m_val, m_idx);
            m_sel <= 3'(1 << m_idx);
            if (m_rc == RD - 1) begin
                m_rc  <= 0;
                m_idx <= (m_idx + 1) % DG;
            end else begin
                m_rc <= m_rc + 1;
            end
            m_pre  <= np;
            m_val  <= nv;
            m_tick <= nt;
            m_wrap <= nw;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("model_segments", 32'(segments), 32'(m_seg));
            checkOutput("model_digit_sel", 32'(digit_sel), 32'(m_sel));
            checkOutput("model_tick", 32'(tick), 32'(m_tick));
            checkOutput("model_wrap", 32'(wrap), 32'(m_wrap));
        end
    end

    task automatic waitTick(input int max_cycles, output int cycles, output logic got, output logic w);
        cycles = 0;
        got    = 1'b0;
        w      = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            @(negedge clk);
            cycles++;
            if (tick) begin
                got = 1'b1;
                w   = wrap;
            end
        end
        if (!got) checkOutput("tick_timeout", 32'd0, 32'd1);
    endtask

    // Pauses the counter and captures one full scan round as {digit2, digit1, digit0}.
    task automatic readDisplay(output logic [20:0] s);
        s = '1;
        applyStimulus(1'b0, up, 1'b0);
        for (int i = 0; i < DG * RD; i++) begin
            @(negedge clk);
            case (digit_sel)
                3'b001:  s[6:0]   = segments;
                3'b010:  s[13:7]  = segments;
                3'b100:  s[20:14] = segments;
                default: ;
            endcase
        end
    endtask

    typedef struct {
        logic        up;
        int          n;
        int          exp_wraps;
        logic [20:0] exp_segs;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          cyc;
        int          wraps;
        int          bad_period;
        int          seen;
        logic        got;
        logic        w;
        logic [20:0] s;

        tbl[0] = '{1'b0,   1, 1, {7'h6F, 7'h6F, 7'h6F}};
        tbl[1] = '{1'b1,   1, 1, {7'h00, 7'h00, 7'h3F}};
        tbl[2] = '{1'b0, 900, 1, {7'h06, 7'h3F, 7'h3F}};
        tbl[3] = '{1'b0,   1, 0, {7'h00, 7'h6F, 7'h6F}};
        tbl[4] = '{1'b0,  94, 0, {7'h00, 7'h00, 7'h6D}};
        tbl[5] = '{1'b1,   5, 0, {7'h00, 7'h06, 7'h3F}};
        tbl[6] = '{1'b0,   1, 0, {7'h00, 7'h00, 7'h6F}};
        tbl[7] = '{1'b1,  89, 0, {7'h00, 7'h6F, 7'h7F}};
        tbl[8] = '{1'b1,   1, 0, {7'h00, 7'h6F, 7'h6F}};

        $display("[TB] reset and first step");
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_segments", 32'(segments), 32'h3F);
        checkOutput("reset_digit_sel", 32'(digit_sel), 32'h1);
        checkOutput("reset_tick", 32'(tick), 32'h0);
        checkOutput("reset_wrap", 32'(wrap), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitTick(CD + 4, cyc, got, w);
        checkOutput("first_tick_latency", 32'(cyc), 32'(CD));
        readDisplay(s);
        checkOutput("display_001", 32'(s), 32'({7'h00, 7'h00, 7'h06}));

        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        readDisplay(s);
        checkOutput("display_after_clear", 32'(s), 32'({7'h00, 7'h00, 7'h3F}));

        $display("[TB] table vectors");
        for (int r = 0; r < 9; r++) begin
            wraps      = 0;
            bad_period = 0;
            applyStimulus(1'b1, tbl[r].up, 1'b0);
            for (int t = 0; t < tbl[r].n; t++) begin
                waitTick(CD + 2, cyc, got, w);
                if (w) wraps++;
                if (cyc != CD) bad_period++;
            end
            readDisplay(s);
            checkOutput($sformatf("row%0d_wraps", r), 32'(wraps), 32'(tbl[r].exp_wraps));
            checkOutput($sformatf("row%0d_period", r), 32'(bad_period), 32'd0);
            checkOutput($sformatf("row%0d_display", r), 32'(s), 32'(tbl[r].exp_segs));
        end

        $display("[TB] pause mid-period");
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (tick) seen++;
        end
        checkOutput("paused_ticks", 32'(seen), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitTick(CD + 2, cyc, got, w);
        checkOutput("resume_latency", 32'(cyc), 32'd2);

        $display("[TB] clear on terminal count");
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("clear_wins_tick", 32'(tick), 32'd0);
        readDisplay(s);
        checkOutput("clear_wins_display", 32'(s), 32'({7'h00, 7'h00, 7'h3F}));

        $display("[TB] random phase");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(logic'($urandom_range(0, 9) != 0),
                          logic'($urandom_range(0, 1)),
                          logic'($urandom_range(0, 49) == 0));
            @(negedge clk);
        end

        $display("[TB] asynchronous reset");
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_segments", 32'(segments), 32'h3F);
        checkOutput("async_reset_digit_sel", 32'(digit_sel), 32'h1);
        checkOutput("async_reset_tick", 32'(tick), 32'h0);
        checkOutput("async_reset_wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitTick(CD + 4, cyc, got, w);
        checkOutput("post_reset_latency", 32'(cyc), 32'(CD));
        checkOutput("post_reset_down_wrap", 32'(w), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
